// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if: CPU-side fetch handshake and instruction RAM port bundle.
interface imem_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic              cpu_gnt_o;
    logic              cpu_rvalid_o;
    logic              cpu_rready_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_err_o;
    logic              flush_i;
    logic              instr_req_o;
    logic              instr_gnt_i;
    logic [ADDR_W-1:0] instr_addr_o;
    logic              instr_rvalid_i;
    logic [DATA_W-1:0] instr_rdata_i;
    logic [6:0]        instr_rdata_intg_i;
    logic              instr_err_i;
    modport slave (
        input  cpu_req_i, cpu_addr_i, cpu_rready_i, flush_i, instr_gnt_i,
               instr_rvalid_i, instr_rdata_i, instr_rdata_intg_i, instr_err_i,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_err_o, instr_req_o, instr_addr_o
    );
    modport master (
        output cpu_req_i, cpu_addr_i, cpu_rready_i, flush_i, instr_gnt_i,
               instr_rvalid_i, instr_rdata_i, instr_rdata_intg_i, instr_err_i,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_err_o, instr_req_o, instr_addr_o
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: registered req/gnt/rvalid instruction fetch with outstanding tracking,
// response FIFO and flush-driven discard of stale responses.
module imem_fetch_unit #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIFO_DEPTH      = 2
) (
    input logic clk_i,
    input logic rst_i,
    imem_fetch_unit_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = (CW > FW ? CW : FW) + 2;
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0] outstanding, outstanding_n, discard, discard_n;
    logic pend_disc, pend_disc_n;
    logic [FW-1:0] count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic gnt_fire, gnt_to_disc, gnt_to_out, rv_disc, rv_push, push, pop, credit_ok, accept;
    logic [SW-1:0] ram_need, fifo_need;
    logic unused_intg;
    assign unused_intg = ^bus.instr_rdata_intg_i;
    always_comb begin
        gnt_fire      = state == REQ && bus.instr_gnt_i;
        // a grant for a request issued before a flush carries stale data
        gnt_to_disc   = gnt_fire && (pend_disc || bus.flush_i);
        gnt_to_out    = gnt_fire && !gnt_to_disc;
        rv_disc       = bus.instr_rvalid_i && discard != '0;
        rv_push       = bus.instr_rvalid_i && discard == '0 && outstanding != '0;
        // discards still occupy the RAM, so they count against the in-flight limit
        ram_need      = SW'(outstanding) + SW'(discard) + SW'(gnt_fire);
        fifo_need     = SW'(outstanding) + SW'(count) + SW'(gnt_to_out);
        credit_ok     = ram_need < SW'(MAX_OUTSTANDING) && fifo_need < SW'(FIFO_DEPTH);
        accept        = bus.cpu_req_i && !bus.flush_i && (state == IDLE || gnt_fire) && credit_ok;
        push          = rv_push && !bus.flush_i;
        pop           = count != '0 && bus.cpu_rready_i && !bus.flush_i;
        state_n       = accept ? REQ : gnt_fire ? IDLE : state;
        pend_disc_n   = state_n == REQ && !accept && (pend_disc || bus.flush_i);
        outstanding_n = bus.flush_i ? '0 : outstanding + CW'(gnt_to_out) - CW'(rv_push);
        discard_n     = bus.flush_i
                      ? discard + outstanding + CW'(gnt_fire) - CW'(rv_disc) - CW'(rv_push)
                      : discard + CW'(gnt_to_disc) - CW'(rv_disc);
    end
    assign bus.cpu_gnt_o    = accept;
    assign bus.instr_req_o  = state == REQ;
    assign bus.instr_addr_o = addr_q;
    assign bus.cpu_rvalid_o = count != '0;
    assign bus.cpu_rdata_o  = count != '0 ? mem[rd_ptr][DATA_W-1:0] : '0;
    assign bus.cpu_err_o    = count != '0 && mem[rd_ptr][DATA_W];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            outstanding <= '0;
            discard     <= '0;
            pend_disc   <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            pend_disc   <= pend_disc_n;
            if (accept) addr_q <= {bus.cpu_addr_i[ADDR_W-1:2], 2'b00};
            if (bus.flush_i) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + FW'(push) - FW'(pop);
                if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {bus.instr_err_i, bus.instr_rdata_i};
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed fetch scenarios with a response scoreboard.
module tb_imem_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int passed = 0;
    int total = 0;
    logic [32:0] exp_q[$];
    always #5 clk = ~clk;
    imem_fetch_unit_if bus ();
    imem_fetch_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fetch_granted(input logic [31:0] addr);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_addr_i = addr;
        settle();
        chk("fetch_gnt", bus.cpu_gnt_o, 1);
        tick();
        bus.cpu_req_i   = 1'b0;
        bus.instr_gnt_i = 1'b1;
        tick();
        bus.instr_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err, input logic deliver);
        bus.instr_rvalid_i = 1'b1;
        bus.instr_rdata_i  = data;
        bus.instr_err_i    = err;
        if (deliver) exp_q.push_back({err, data});
        tick();
        bus.instr_rvalid_i = 1'b0;
        bus.instr_err_i    = 1'b0;
    endtask

    task automatic drain();
        bus.cpu_rready_i = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", exp_q.size(), 0);
        bus.cpu_rready_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.cpu_rvalid_o && bus.cpu_rready_i && !bus.flush_i) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("resp", {bus.cpu_err_o, bus.cpu_rdata_o}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.cpu_req_i = 0; bus.cpu_addr_i = 0; bus.cpu_rready_i = 0; bus.flush_i = 0;
        bus.instr_gnt_i = 0; bus.instr_rvalid_i = 0; bus.instr_rdata_i = 0;
        bus.instr_rdata_intg_i = 0; bus.instr_err_i = 0;
        tick();
        tick();
        chk("rst_req", bus.instr_req_o, 0);
        chk("rst_addr", bus.instr_addr_o, 0);
        chk("rst_gnt", bus.cpu_gnt_o, 0);
        chk("rst_rvalid", bus.cpu_rvalid_o, 0);
        chk("rst_rdata", bus.cpu_rdata_o, 0);
        chk("rst_err", bus.cpu_err_o, 0);
        rst = 1'b0;
        tick();
        // single fetch
        bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h10;
        settle();
        chk("t1_gnt", bus.cpu_gnt_o, 1);
        tick();
        bus.cpu_req_i = 0;
        settle();
        chk("t1_req", bus.instr_req_o, 1);
        chk("t1_addr", bus.instr_addr_o, 32'h10);
        bus.instr_gnt_i = 1;
        tick();
        bus.instr_gnt_i = 0;
        settle();
        chk("t1_req_drop", bus.instr_req_o, 0);
        bus.instr_rvalid_i = 1; bus.instr_rdata_i = 32'h13;
        exp_q.push_back({1'b0, 32'h13});
        settle();
        chk("t1_no_bypass", bus.cpu_rvalid_o, 0);
        tick();
        bus.instr_rvalid_i = 0;
        settle();
        chk("t1_rvalid", bus.cpu_rvalid_o, 1);
        chk("t1_rdata", bus.cpu_rdata_o, 32'h13);
        drain();
        // delayed grant, address change held off
        bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h20;
        settle();
        chk("t2_gnt", bus.cpu_gnt_o, 1);
        tick();
        bus.cpu_addr_i = 32'h44;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_req_hold", bus.instr_req_o, 1);
            chk("t2_addr_hold", bus.instr_addr_o, 32'h20);
            chk("t2_gnt_block", bus.cpu_gnt_o, 0);
            tick();
        end
        bus.instr_gnt_i = 1;
        settle();
        chk("t2_gnt_on_grant", bus.cpu_gnt_o, 1);
        tick();
        bus.instr_gnt_i = 0; bus.cpu_req_i = 0;
        settle();
        chk("t2_addr2", bus.instr_addr_o, 32'h44);
        chk("t2_req2", bus.instr_req_o, 1);
        bus.instr_gnt_i = 1;
        tick();
        bus.instr_gnt_i = 0;
        respond(32'hA0, 0, 1);
        respond(32'hA1, 0, 1);
        drain();
        // pipelined fetch with backpressure
        bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0;
        tick();
        bus.cpu_addr_i = 32'h4; bus.instr_gnt_i = 1;
        settle();
        chk("t3_gnt_b2b", bus.cpu_gnt_o, 1);
        tick();
        bus.cpu_addr_i = 32'h8;
        settle();
        chk("t3_gnt_third", bus.cpu_gnt_o, 0);
        tick();
        bus.instr_gnt_i = 0;
        settle();
        chk("t3_gnt_max", bus.cpu_gnt_o, 0);
        respond(32'h1000, 0, 1);
        respond(32'h1004, 0, 1);
        settle();
        chk("t3_gnt_full", bus.cpu_gnt_o, 0);
        chk("t3_head", bus.cpu_rdata_o, 32'h1000);
        bus.cpu_rready_i = 1;
        tick();
        bus.cpu_rready_i = 0;
        settle();
        chk("t3_gnt_after_pop", bus.cpu_gnt_o, 1);
        tick();
        bus.cpu_req_i = 0;
        settle();
        chk("t3_addr8", bus.instr_addr_o, 32'h8);
        bus.instr_gnt_i = 1;
        tick();
        bus.instr_gnt_i = 0;
        respond(32'h1008, 0, 1);
        drain();
        // flush with two outstanding
        fetch_granted(32'h30);
        fetch_granted(32'h34);
        bus.flush_i = 1; bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h100;
        settle();
        chk("t4_gnt_flush", bus.cpu_gnt_o, 0);
        tick();
        bus.flush_i = 0; bus.cpu_req_i = 0;
        exp_q.delete();
        settle();
        chk("t4_fifo_empty", bus.cpu_rvalid_o, 0);
        respond(32'hDEAD, 0, 0);
        respond(32'hBEEF, 0, 0);
        settle();
        chk("t4_discarded", bus.cpu_rvalid_o, 0);
        fetch_granted(32'h100);
        respond(32'h2100, 0, 1);
        settle();
        chk("t4_first_rvalid", bus.cpu_rvalid_o, 1);
        chk("t4_first_rdata", bus.cpu_rdata_o, 32'h2100);
        drain();
        // error flag travels with its entry only
        fetch_granted(32'h40);
        fetch_granted(32'h44);
        respond(32'h3000, 1, 1);
        settle();
        chk("t5_err", bus.cpu_err_o, 1);
        respond(32'h3004, 0, 1);
        drain();
        // reset with a pending request and one outstanding
        fetch_granted(32'h50);
        bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h54;
        tick();
        bus.cpu_req_i = 0;
        settle();
        chk("t6_pending", bus.instr_req_o, 1);
        rst = 1;
        tick();
        exp_q.delete();
        chk("t6_req", bus.instr_req_o, 0);
        chk("t6_addr", bus.instr_addr_o, 0);
        chk("t6_gnt", bus.cpu_gnt_o, 0);
        chk("t6_rvalid", bus.cpu_rvalid_o, 0);
        rst = 0;
        respond(32'hBAD, 0, 0);
        settle();
        chk("t6_stray", bus.cpu_rvalid_o, 0);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
